// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W         = 5;
  localparam int INTERNAL_BITS = 2;

  localparam logic [INTERNAL_BITS-1:0] ST_RUN      = 2'd0;
  localparam logic [INTERNAL_BITS-1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [INTERNAL_BITS-1:0] ST_ERR      = 2'd2;

  // One bit per pipeline-register control line, PC first.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
    logic ex_mem_flush;
    logic mem_wb_write;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = ctrl_t'(8'b1101_0101);
  localparam ctrl_t CTRL_FREEZE  = ctrl_t'(8'b0000_0000);
  localparam ctrl_t CTRL_RESET   = ctrl_t'(8'b0010_1010);
  localparam ctrl_t CTRL_BRANCH  = ctrl_t'(8'b1111_1111);
  localparam ctrl_t CTRL_BUBBLE  = ctrl_t'(8'b0001_1101);

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_rt,
  output logic             load_use
);

  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_rt != '0) &&
               ((ID_EX_rt == ID_rs) || (ID_uses_rt && (ID_EX_rt == ID_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, taken-branch squash, memory-wait freeze,
// wait timeout and saturating performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_uses_rt,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_rt,
  input  logic             MEM_branch_taken,
  input  logic             MEM_mem_req,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             EX_MEM_flush,
  output logic             MEM_WB_write,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [INTERNAL_BITS-1:0] state;
  logic [INTERNAL_BITS-1:0] state_nxt;
  logic [WAIT_W-1:0]        wait_cnt;
  logic                     load_use;
  logic                     mem_stall;
  logic                     run_rules;
  logic                     branch_evt;
  ctrl_t                    ctrl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_detect u_hazard_detect (
    .ID_rs         (ID_rs),
    .ID_rt         (ID_rt),
    .ID_uses_rt    (ID_uses_rt),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_rt      (ID_EX_rt),
    .load_use      (load_use)
  );

  // Next state and control decode; the cycle memory completes is handled as a RUN cycle.
  always_comb begin
    mem_stall = MEM_mem_req & ~dmem_ready;
    state_nxt = state;
    run_rules = 1'b0;
    ctrl      = CTRL_FREEZE;
    case (state)
      ST_RUN: begin
        if (mem_stall) state_nxt = ST_MEM_WAIT;
        else           run_rules = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = ST_RUN;
          run_rules = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_ERR;
        end
      end
      default: state_nxt = ST_ERR;
    endcase
    branch_evt = run_rules & MEM_branch_taken;
    if (run_rules) begin
      // A taken branch wins over load-use: the stalled instruction is wrong-path.
      if (MEM_branch_taken) ctrl = CTRL_BRANCH;
      else if (load_use)    ctrl = CTRL_BUBBLE;
      else                  ctrl = CTRL_DEFAULT;
    end
    if (rst) ctrl = CTRL_RESET;
  end

  assign PC_write     = ctrl.pc_write;
  assign IF_ID_write  = ctrl.if_id_write;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign ID_EX_write  = ctrl.id_ex_write;
  assign ID_EX_flush  = ctrl.id_ex_flush;
  assign EX_MEM_write = ctrl.ex_mem_write;
  assign EX_MEM_flush = ctrl.ex_mem_flush;
  assign MEM_WB_write = ctrl.mem_wb_write;

  // FSM state, memory-wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_RUN && mem_stall)
        wait_cnt <= WAIT_W'(1);
      else if (state == ST_MEM_WAIT)
        wait_cnt <= dmem_ready ? '0 : wait_cnt + 1'b1;
      if (state == ST_MEM_WAIT && !dmem_ready && wait_cnt == WAIT_LAST)
        timeout_err <= 1'b1;
    end
  end

  // Saturating counts of PC-stalled cycles and taken-branch flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ctrl.pc_write) stall_cnt <= sat_inc(stall_cnt);
      if (branch_evt)     flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a behavioural model of the sequencer.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  localparam logic [7:0] O_DEF    = 8'b1101_0101;
  localparam logic [7:0] O_BUBBLE = 8'b0001_1101;
  localparam logic [7:0] O_BRANCH = 8'b1111_1111;
  localparam logic [7:0] O_FREEZE = 8'b0000_0000;
  localparam logic [7:0] O_RESET  = 8'b0010_1010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] ID_rs, ID_rt, ID_EX_rt;
  logic       ID_uses_rt, ID_EX_MemRead, MEM_branch_taken, MEM_mem_req, dmem_ready;
  logic       PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush;
  logic       EX_MEM_write, EX_MEM_flush, MEM_WB_write, timeout_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
    .MEM_branch_taken(MEM_branch_taken), .MEM_mem_req(MEM_mem_req), .dmem_ready(dmem_ready),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_write(ID_EX_write), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_write(EX_MEM_write), .EX_MEM_flush(EX_MEM_flush), .MEM_WB_write(MEM_WB_write),
    .timeout_err(timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: where the pipe is (0 running, 1 waiting on memory, 2 timed out) and how long it waited.
  int m_mode   = 0;
  int m_waited = 0;
  int m_err    = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  logic [7:0]       last_out;
  logic             last_err;
  logic [CNT_W-1:0] last_stall, last_flush;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic idle();
    ID_rs = 0; ID_rt = 0; ID_uses_rt = 0; ID_EX_MemRead = 0; ID_EX_rt = 0;
    MEM_branch_taken = 0; MEM_mem_req = 0; dmem_ready = 1;
  endtask

  // One clock: sample on the falling edge, compare with the model, advance the model.
  task automatic step();
    logic [7:0] exp;
    bit lu, ms, freeze;
    @(negedge clk);
    last_out   = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
                  EX_MEM_write, EX_MEM_flush, MEM_WB_write};
    last_err   = timeout_err;
    last_stall = stall_cnt;
    last_flush = flush_cnt;
    check("timeout_err", {31'd0, last_err}, m_err);
    check("stall_cnt", {28'd0, last_stall}, m_stall);
    check("flush_cnt", {28'd0, last_flush}, m_flush);
    lu = ID_EX_MemRead && ID_EX_rt != 0 &&
         (ID_EX_rt == ID_rs || (ID_uses_rt && ID_EX_rt == ID_rt));
    ms = MEM_mem_req && !dmem_ready;
    if (rst) begin
      check("outputs_in_reset", {24'd0, last_out}, {24'd0, O_RESET});
      m_mode = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      freeze = (m_mode == 2) || (m_mode == 0 && ms) || (m_mode == 1 && !dmem_ready);
      if (freeze)                exp = O_FREEZE;
      else if (MEM_branch_taken) exp = O_BRANCH;
      else if (lu)               exp = O_BUBBLE;
      else                       exp = O_DEF;
      check("outputs", {24'd0, last_out}, {24'd0, exp});
      if (!exp[7] && m_stall < CMAX) m_stall++;
      if (!freeze && MEM_branch_taken && m_flush < CMAX) m_flush++;
      if (m_mode == 0 && ms) begin
        m_mode = 1; m_waited = 1;
      end else if (m_mode == 1) begin
        if (dmem_ready) begin
          m_mode = 0; m_waited = 0;
        end else if (m_waited == MAX_WAIT - 1) begin
          m_mode = 2; m_err = 1;
        end else begin
          m_waited++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; step(); step();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    @(posedge clk);
    #1;
    step();
    check("reset_outputs_lit", {24'd0, last_out}, {24'd0, O_RESET});
    step();
    rst = 0;

    // lw $2 followed by add $3,$2,$4
    ID_EX_MemRead = 1; ID_EX_rt = 2; ID_rs = 2; ID_rt = 4; ID_uses_rt = 1;
    step();
    check("t1_bubble_lit", {24'd0, last_out}, {24'd0, O_BUBBLE});
    idle(); step();
    check("t1_after_lit", {24'd0, last_out}, {24'd0, O_DEF});
    check("t1_stall_cnt_lit", {28'd0, last_stall}, 32'd1);

    // load into $0 never stalls
    ID_EX_MemRead = 1; ID_EX_rt = 0; ID_rs = 0;
    step();
    check("t2_no_stall_lit", {24'd0, last_out}, {24'd0, O_DEF});

    // taken branch and load-use in the same cycle
    ID_EX_MemRead = 1; ID_EX_rt = 7; ID_rs = 7; MEM_branch_taken = 1;
    step();
    check("t3_branch_lit", {24'd0, last_out}, {24'd0, O_BRANCH});
    idle(); step();
    check("t3_flush_cnt_lit", {28'd0, last_flush}, 32'd1);

    // three-cycle memory wait
    do_reset();
    MEM_mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_frozen_lit", {24'd0, last_out}, {24'd0, O_FREEZE});
    end
    dmem_ready = 1; step();
    check("t4_resume_lit", {24'd0, last_out}, {24'd0, O_DEF});
    idle(); step();
    check("t4_stall_cnt_lit", {28'd0, last_stall}, 32'd3);

    // reset while waiting on memory
    do_reset();
    MEM_mem_req = 1; dmem_ready = 0;
    step(); step();
    rst = 1; step();
    check("t6_reset_outs_lit", {24'd0, last_out}, {24'd0, O_RESET});
    rst = 0; idle(); step();
    check("t6_after_lit", {24'd0, last_out}, {24'd0, O_DEF});
    check("t6_stall_zero_lit", {28'd0, last_stall}, 32'd0);
    check("t6_err_zero_lit", {31'd0, last_err}, 32'd0);

    // memory never answers: timeout after MAX_WAIT frozen cycles
    do_reset();
    MEM_mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < MAX_WAIT; i++) step();
    check("t5_err_not_yet_lit", {31'd0, last_err}, 32'd0);
    step();
    check("t5_err_lit", {31'd0, last_err}, 32'd1);
    check("t5_stall_sat_lit", {28'd0, last_stall}, CMAX);
    dmem_ready = 1; MEM_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_stuck_lit", {24'd0, last_out}, {24'd0, O_FREEZE});
    end
    do_reset();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst              = ($urandom_range(0, 299) == 0) || (m_mode == 2 && $urandom_range(0, 9) == 0);
      ID_rs            = 5'($urandom_range(0, 3));
      ID_rt            = 5'($urandom_range(0, 3));
      ID_EX_rt         = 5'($urandom_range(0, 3));
      ID_uses_rt       = 1'($urandom_range(0, 1));
      ID_EX_MemRead    = 1'($urandom_range(0, 1));
      MEM_branch_taken = ($urandom_range(0, 4) == 0);
      MEM_mem_req      = ($urandom_range(0, 2) == 0);
      dmem_ready       = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
